decode_ctrl: RTL and testbench
==============================

# decode_ctrl

Decode-stage controller for the pipelined RV32I core. Holds the IF/ID slot, drives the combinational immediate generator with the held instruction, and selects the correct immediate format from the opcode. Registers the result into the ID/EX slot under a valid/ready handshake with flush and optional load-use interlock. Sits between the fetch stage and the execute stage.

## Interface
- No parameters.
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_inst  in  32  fetched instruction
- if_pc  in  32  PC of if_inst
- id_ready  out  1  decode accepts if_inst this cycle
- flush  in  1  squash ID and EX slots (taken branch/jump resolved in EX)
- gen_inst  out  32  instruction driven to immediate generator (= held ID instruction)
- i_imm, s_imm, b_imm, j_imm, u_imm  in  32 each  immediate generator outputs for gen_inst
- ex_ready  in  1  execute consumes the ID/EX slot this cycle
- ex_valid  out  1  ID/EX slot holds a live instruction
- ex_pc, ex_inst, ex_imm  out  32 each  registered PC, instruction, selected immediate
- ex_fmt  out  3  0=R,1=I,2=S,3=B,4=J,5=U,7=illegal
- ex_rd  out  5  inst[11:7], forced 0 for S/B/illegal
- ex_is_load  out  1  opcode 0000011
- ex_illegal  out  1  opcode not recognised
- stall_cnt  out  16  load-use stall cycles, saturating

## Operation
- Format decode on inst[6:0]: 0010011/0000011/1100111/1110011→I; 0100011→S; 1100011→B; 1101111→J; 0110111/0010111→U; 0110011→R (imm=0); else illegal (imm=0, ex_illegal=1).
- Register usage: rs1 (inst[19:15]) used by R/I/S/B; rs2 (inst[24:20]) used by R/S/B; U/J/illegal use none.
- ID slot: id_valid, id_inst, id_pc. EX slot: all ex_* outputs.
- ex_free = !ex_valid || ex_ready.
- advance = id_valid && ex_free && !hazard → EX slot loads ID contents and selected immediate.
- id_ready = rst_n && (!id_valid || advance). Accept = if_valid && id_ready → ID slot loads if_inst/if_pc.
- If ex_free and not advancing, ex_valid ← 0 (bubble); other ex_* hold.
- hazard (interlock only) = id_valid && ex_valid && ex_is_load && ex_rd≠0 && (rs1==ex_rd with rs1 used, or rs2==ex_rd with rs2 used). On hazard with ex_ready: bubble into EX, ID holds, stall_cnt += 1 (saturates at 0xFFFF). Next cycle EX is empty, so the held instruction advances.
- flush: at that edge id_valid ← 0, ex_valid ← 0, no accept even if if_valid && id_ready; flush dominates hazard and advance. stall_cnt not incremented.
- gen_inst = id_inst combinationally; immediate selection reads generator outputs in the same cycle.

## Timing
- Reset (rst_n low at an edge): id_valid=0, ex_valid=0, all ex_* data outputs 0, ex_fmt=0, stall_cnt=0; id_ready=0 while rst_n low, 1 in the first cycle after.
- Latency: instruction accepted at edge N appears on ex_* after edge N+1 if no stall (2 stages).
- Throughput: one instruction per cycle with ex_ready held high and no hazard.
- Backpressure: ex_ready=0 with ex_valid=1 holds the EX slot; ID fills, then id_ready drops the following cycle.
- Simultaneous accept and advance: ID slot replaced same edge (full-throughput case).
- Reset mid-operation discards both slots; no partial state retained.

## Configuration
- DECODE_LOAD_USE_INTERLOCK_EN defined: hazard logic and stall_cnt active as above.
- Undefined: hazard constant 0, load results rely on forwarding elsewhere; stall_cnt tied to 0; ports unchanged.

## Test plan
- Reset then stream addi x1,x0,5 (0x00500093), ex_ready=1 → two edges later ex_valid=1, ex_fmt=1, ex_imm=5, ex_rd=1.
- Stream sw, beq, jal, lui back-to-back → one per cycle, ex_fmt 2/3/4/5 with imm equal to matching generator input, ex_rd=0 for sw/beq.
- lw x5,0(x1) followed by add x6,x5,x2 (interlock on) → one bubble cycle (ex_valid=0), add emerges next cycle, stall_cnt=1; with macro off no bubble, stall_cnt=0.
- lw x0 followed by use of x0 → no stall.
- Hold ex_ready=0 for 3 cycles with continuous if_valid → EX holds, id_ready low after ID fills, no instruction lost or duplicated on release.
- Assert flush with both slots full and if_valid=1 → next cycle ex_valid=0, id_valid=0, incoming instruction dropped; opcode 0x7F → ex_illegal=1, ex_imm=0.

Source files
------------

// File: rtl/decode_ctrl.sv
// -----------------------------------------------------------------------------
// decode_ctrl
//
// Decode-stage controller for the pipelined RV32I core. Holds the IF/ID slot,
// drives the external immediate generator with the held instruction, picks the
// immediate format from the opcode and registers the result into the ID/EX
// slot under a valid/ready handshake. A flush squashes both slots.
//
// Optional feature (compile-time macro DECODE_LOAD_USE_INTERLOCK_EN):
//   defined   -> load-use hazard detection inserts one bubble into EX and
//                counts stall cycles in stall_cnt (saturating at 0xFFFF).
//   undefined -> no interlock (forwarding handles loads elsewhere),
//                stall_cnt is tied to zero. Port list is identical.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_valid/if_inst/if_pc     fetch-side instruction offer
//   id_ready                   decode accepts the offer this cycle
//   flush                      squash ID and EX slots
//   gen_inst                   held ID instruction to the immediate generator
//   i/s/b/j/u_imm              immediate generator results for gen_inst
//   ex_ready                   execute consumes the ID/EX slot this cycle
//   ex_valid, ex_pc, ex_inst,
//   ex_imm, ex_fmt, ex_rd,
//   ex_is_load, ex_illegal     registered ID/EX slot contents
//   stall_cnt                  load-use stall cycle counter
// -----------------------------------------------------------------------------
module decode_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        flush,
  output logic [31:0] gen_inst,
  input  logic [31:0] i_imm,
  input  logic [31:0] s_imm,
  input  logic [31:0] b_imm,
  input  logic [31:0] j_imm,
  input  logic [31:0] u_imm,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_imm,
  output logic [2:0]  ex_fmt,
  output logic [4:0]  ex_rd,
  output logic        ex_is_load,
  output logic        ex_illegal,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_J   = 3'd4,
    FMT_U   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // IF/ID slot
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic [31:0] id_pc_q,    id_pc_d;

  // ID/EX slot
  logic        ex_valid_q,   ex_valid_d;
  logic [31:0] ex_pc_q,      ex_pc_d;
  logic [31:0] ex_inst_q,    ex_inst_d;
  logic [31:0] ex_imm_q,     ex_imm_d;
  fmt_e        ex_fmt_q,     ex_fmt_d;
  logic [4:0]  ex_rd_q,      ex_rd_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic        ex_illegal_q, ex_illegal_d;

  // Decode of the held ID instruction
  fmt_e        id_fmt;
  logic [31:0] id_imm;
  logic        id_writes_rd;

  logic ex_free;
  logic hazard;
  logic advance;
  logic accept;

  assign gen_inst = id_inst_q;

  always_comb begin
    id_fmt = FMT_ILL;
    unique case (id_inst_q[6:0])
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM: id_fmt = FMT_I;
      OP_STORE:                             id_fmt = FMT_S;
      OP_BRANCH:                            id_fmt = FMT_B;
      OP_JAL:                               id_fmt = FMT_J;
      OP_LUI, OP_AUIPC:                     id_fmt = FMT_U;
      OP_OP:                                id_fmt = FMT_R;
      default:                              id_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    id_imm = '0;
    unique case (id_fmt)
      FMT_I:   id_imm = i_imm;
      FMT_S:   id_imm = s_imm;
      FMT_B:   id_imm = b_imm;
      FMT_J:   id_imm = j_imm;
      FMT_U:   id_imm = u_imm;
      default: id_imm = '0;
    endcase
  end

  // Stores, branches and unrecognised opcodes carry no destination register.
  assign id_writes_rd = !(id_fmt == FMT_S || id_fmt == FMT_B || id_fmt == FMT_ILL);

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
  logic        rs1_used;
  logic        rs2_used;
  logic        rs1_hit;
  logic        rs2_hit;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign rs1_used = (id_fmt == FMT_R) || (id_fmt == FMT_I) ||
                    (id_fmt == FMT_S) || (id_fmt == FMT_B);
  assign rs2_used = (id_fmt == FMT_R) || (id_fmt == FMT_S) || (id_fmt == FMT_B);
  assign rs1_hit  = rs1_used && (id_inst_q[19:15] == ex_rd_q);
  assign rs2_hit  = rs2_used && (id_inst_q[24:20] == ex_rd_q);

  assign hazard = id_valid_q && ex_valid_q && ex_is_load_q &&
                  (ex_rd_q != 5'd0) && (rs1_hit || rs2_hit);

  // A stall cycle is one where the load actually leaves EX but the consumer
  // is held back; a flush on the same edge cancels the stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!flush && hazard && ex_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign hazard    = 1'b0;
  assign stall_cnt = '0;
`endif

  assign ex_free  = !ex_valid_q || ex_ready;
  assign advance  = id_valid_q && ex_free && !hazard;
  assign id_ready = rst_n && (!id_valid_q || advance);
  assign accept   = if_valid && id_ready && !flush;

  always_comb begin
    id_valid_d   = id_valid_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_inst_d    = ex_inst_q;
    ex_imm_d     = ex_imm_q;
    ex_fmt_d     = ex_fmt_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    ex_illegal_d = ex_illegal_q;

    if (flush) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end else begin
      if (advance) begin
        ex_valid_d   = 1'b1;
        ex_pc_d      = id_pc_q;
        ex_inst_d    = id_inst_q;
        ex_imm_d     = id_imm;
        ex_fmt_d     = id_fmt;
        ex_rd_d      = id_writes_rd ? id_inst_q[11:7] : 5'd0;
        ex_is_load_d = (id_inst_q[6:0] == OP_LOAD);
        ex_illegal_d = (id_fmt == FMT_ILL);
      end else if (ex_free) begin
        ex_valid_d = 1'b0;
      end

      // Accept takes priority so a same-edge advance+accept refills ID.
      if (accept) begin
        id_valid_d = 1'b1;
        id_inst_d  = if_inst;
        id_pc_d    = if_pc;
      end else if (advance) begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_q   <= 1'b0;
      id_inst_q    <= '0;
      id_pc_q      <= '0;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_inst_q    <= '0;
      ex_imm_q     <= '0;
      ex_fmt_q     <= FMT_R;
      ex_rd_q      <= '0;
      ex_is_load_q <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      id_valid_q   <= id_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_inst_q    <= ex_inst_d;
      ex_imm_q     <= ex_imm_d;
      ex_fmt_q     <= ex_fmt_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_inst    = ex_inst_q;
  assign ex_imm     = ex_imm_q;
  assign ex_fmt     = ex_fmt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_decode_ctrl.sv
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic [31:0] gen_inst;
  logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_imm;
  logic [2:0]  ex_fmt;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_illegal;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .id_ready(id_ready), .flush(flush), .gen_inst(gen_inst),
    .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .j_imm(j_imm), .u_imm(u_imm),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_imm(ex_imm), .ex_fmt(ex_fmt), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
  );

  // RV32I immediate generator (environment of the DUT)
  function automatic logic [31:0] f_i(input logic [31:0] x);
    return {{20{x[31]}}, x[31:20]};
  endfunction
  function automatic logic [31:0] f_s(input logic [31:0] x);
    return {{20{x[31]}}, x[31:25], x[11:7]};
  endfunction
  function automatic logic [31:0] f_b(input logic [31:0] x);
    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] f_j(input logic [31:0] x);
    return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] f_u(input logic [31:0] x);
    return {x[31:12], 12'b0};
  endfunction

  assign i_imm = f_i(gen_inst);
  assign s_imm = f_s(gen_inst);
  assign b_imm = f_b(gen_inst);
  assign j_imm = f_j(gen_inst);
  assign u_imm = f_u(gen_inst);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
  } id_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic        ld;
    logic        ill;
  } ex_t;

  id_t m_id;
  ex_t m_ex;
  int  m_stall = 0;
  bit  m_on = 1'b0;

  function automatic int fmt_of(input logic [31:0] inst);
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 1;
      7'h23:                      return 2;
      7'h63:                      return 3;
      7'h6F:                      return 4;
      7'h37, 7'h17:               return 5;
      7'h33:                      return 0;
      default:                    return 7;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] inst);
    case (fmt_of(inst))
      1:       return f_i(inst);
      2:       return f_s(inst);
      3:       return f_b(inst);
      4:       return f_j(inst);
      5:       return f_u(inst);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_hazard();
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    int f;
    if (!(m_id.v && m_ex.v && m_ex.ld && m_ex.rd != 5'd0)) return 1'b0;
    f = fmt_of(m_id.inst);
    return ((f <= 3) && m_id.inst[19:15] == m_ex.rd) ||
           ((f == 0 || f == 2 || f == 3) && m_id.inst[24:20] == m_ex.rd);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_adv();
    return m_id.v && (!m_ex.v || ex_ready) && !m_hazard();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_id    = '{v: 1'b0, inst: 32'd0, pc: 32'd0};
      m_ex    = '{v: 1'b0, pc: 32'd0, inst: 32'd0, imm: 32'd0, fmt: 3'd0,
                  rd: 5'd0, ld: 1'b0, ill: 1'b0};
      m_stall = 0;
      m_on    = 1'b1;
    end else if (flush) begin
      m_id.v = 1'b0;
      m_ex.v = 1'b0;
    end else begin
      logic adv, acc;
      int   f;
      adv = m_adv();
      acc = if_valid && (!m_id.v || adv);
      if (m_hazard() && ex_ready && m_stall < 65535) m_stall++;
      if (adv) begin
        f         = fmt_of(m_id.inst);
        m_ex.v    = 1'b1;
        m_ex.pc   = m_id.pc;
        m_ex.inst = m_id.inst;
        m_ex.imm  = imm_of(m_id.inst);
        m_ex.fmt  = 3'(f);
        m_ex.rd   = (f == 2 || f == 3 || f == 7) ? 5'd0 : m_id.inst[11:7];
        m_ex.ld   = (m_id.inst[6:0] == 7'h03);
        m_ex.ill  = (f == 7);
      end else if (!m_ex.v || ex_ready) begin
        m_ex.v = 1'b0;
      end
      if (acc) m_id = '{v: 1'b1, inst: if_inst, pc: if_pc};
      else if (adv) m_id.v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_id_ready",   {31'd0, id_ready},   {31'd0, rst_n && (!m_id.v || m_adv())});
      chk("m_ex_valid",   {31'd0, ex_valid},   {31'd0, m_ex.v});
      chk("m_ex_pc",      ex_pc,               m_ex.pc);
      chk("m_ex_inst",    ex_inst,             m_ex.inst);
      chk("m_ex_imm",     ex_imm,              m_ex.imm);
      chk("m_ex_fmt",     {29'd0, ex_fmt},     {29'd0, m_ex.fmt});
      chk("m_ex_rd",      {27'd0, ex_rd},      {27'd0, m_ex.rd});
      chk("m_ex_is_load", {31'd0, ex_is_load}, {31'd0, m_ex.ld});
      chk("m_ex_illegal", {31'd0, ex_illegal}, {31'd0, m_ex.ill});
      chk("m_stall_cnt",  {16'd0, stall_cnt},  32'(m_stall));
      if (m_id.v) chk("m_gen_inst", gen_inst, m_id.inst);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic er, input logic fl);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    ex_ready = er;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI5 = 32'h00500093;
  localparam logic [31:0] SW    = 32'h0020A423;
  localparam logic [31:0] BEQ   = 32'h00208863;
  localparam logic [31:0] JAL   = 32'h008000EF;
  localparam logic [31:0] LUI   = 32'h123451B7;
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] ADD6  = 32'h00228333;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADD7  = 32'h000003B3;
  localparam logic [31:0] ILL   = 32'hFFF00FFF;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_fmt",   {29'd0, ex_fmt},   32'd0);
    chk("rst_stall",    {16'd0, stall_cnt}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_id_ready", {31'd0, id_ready}, 32'd1);

    // addi x1,x0,5
    drive(1'b1, ADDI5, 32'h100, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_fmt",   {29'd0, ex_fmt},   32'd1);
    chk("addi_imm",   ex_imm,            32'd5);
    chk("addi_rd",    {27'd0, ex_rd},    32'd1);
    chk("addi_pc",    ex_pc,             32'h100);

    // sw, beq, jal, lui back to back
    drive(1'b1, SW,  32'h104, 1'b1, 1'b0);
    drive(1'b1, BEQ, 32'h108, 1'b1, 1'b0);
    chk("sw_fmt", {29'd0, ex_fmt}, 32'd2);
    chk("sw_imm", ex_imm, 32'd8);
    chk("sw_rd",  {27'd0, ex_rd}, 32'd0);
    drive(1'b1, JAL, 32'h10C, 1'b1, 1'b0);
    chk("beq_fmt", {29'd0, ex_fmt}, 32'd3);
    chk("beq_imm", ex_imm, 32'd16);
    chk("beq_rd",  {27'd0, ex_rd}, 32'd0);
    drive(1'b1, LUI, 32'h110, 1'b1, 1'b0);
    chk("jal_fmt", {29'd0, ex_fmt}, 32'd4);
    chk("jal_imm", ex_imm, 32'd8);
    chk("jal_rd",  {27'd0, ex_rd}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lui_fmt", {29'd0, ex_fmt}, 32'd5);
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd",  {27'd0, ex_rd}, 32'd3);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("drain_valid", {31'd0, ex_valid}, 32'd0);

    // lw x5 followed by add x6,x5,x2
    drive(1'b1, LW5,  32'h200, 1'b1, 1'b0);
    drive(1'b1, ADD6, 32'h204, 1'b1, 1'b0);
    chk("lw_in_ex", ex_inst, LW5);
    chk("lw_is_load", {31'd0, ex_is_load}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall1", {16'd0, stall_cnt}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_inst", ex_inst, ADD6);
`else
    chk("nolu_valid", {31'd0, ex_valid}, 32'd1);
    chk("nolu_add",   ex_inst, ADD6);
    chk("nolu_stall", {16'd0, stall_cnt}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
`endif
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // lw x0 then use of x0: never stalls
    drive(1'b1, LW0,  32'h300, 1'b1, 1'b0);
    drive(1'b1, ADD7, 32'h304, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("x0_no_stall_valid", {31'd0, ex_valid}, 32'd1);
    chk("x0_no_stall_inst",  ex_inst, ADD7);
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    chk("x0_stall_cnt", {16'd0, stall_cnt}, 32'd1);
`else
    chk("x0_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // backpressure: ex_ready low for three edges, fetch keeps offering
    drive(1'b1, 32'h00100093, 32'h400, 1'b1, 1'b0);
    drive(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 32'h408, 1'b0, 1'b0);
    chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
    chk("bp_hold1", ex_inst, 32'h00100093);
    drive(1'b1, 32'h00300093, 32'h408, 1'b0, 1'b0);
    chk("bp_hold2", ex_inst, 32'h00100093);
    chk("bp_valid", {31'd0, ex_valid}, 32'd1);
    drive(1'b1, 32'h00300093, 32'h408, 1'b1, 1'b0);
    chk("bp_rel_i2", ex_inst, 32'h00200093);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_rel_i3", ex_inst, 32'h00300093);
    chk("bp_rel_pc", ex_pc, 32'h408);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_no_dup", {31'd0, ex_valid}, 32'd0);

    // flush with both slots full and an incoming instruction
    drive(1'b1, 32'h00700093, 32'h500, 1'b1, 1'b0);
    drive(1'b1, 32'h00800093, 32'h504, 1'b1, 1'b0);
    drive(1'b1, 32'h00900093, 32'h508, 1'b1, 1'b1);
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_id_empty", {31'd0, id_ready}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fl_dropped", {31'd0, ex_valid}, 32'd0);

    // illegal opcode 0x7F
    drive(1'b1, ILL, 32'h600, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_imm",  ex_imm, 32'd0);
    chk("ill_fmt",  {29'd0, ex_fmt}, 32'd7);
    chk("ill_rd",   {27'd0, ex_rd}, 32'd0);

    // reset mid-operation
    drive(1'b1, 32'h00A00093, 32'h700, 1'b1, 1'b0);
    drive(1'b1, 32'h00B00093, 32'h704, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 32'h00C00093, 32'h708, 1'b1, 1'b0);
    chk("mrst_valid", {31'd0, ex_valid}, 32'd0);
    chk("mrst_inst",  ex_inst, 32'd0);
    chk("mrst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("mrst_ready", {31'd0, id_ready}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("mrst_empty", {31'd0, ex_valid}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
